add_seq100: RTL and testbench

Multi-cycle sequential wide adder that computes a WIDTH-bit sum with carry-in by walking CHUNK-bit slices LSB-first, one slice per clock, with a single carry flop between slices. It sits in the same arithmetic datapath as the combinational 100-bit ripple adder. It is the register-bounded alternative for timing-critical paths: it accepts operands through a valid/ready handshake and presents {cout, sum} through a valid/ready handshake to the downstream consumer.

---
 rtl/add_seq_pkg.sv | 23 ++
 rtl/add_chunk.sv | 24 ++
 rtl/add_seq100.sv | 147 ++++++++++++++
 tb/tb_add_seq100.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared types and sizing helpers for the sequential wide adder.
// The ADD_SEQ_OVF_EN macro (used by the other files) adds the signed-overflow output.
package add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ADD_SEQ_WIDTH = 100;
  localparam int ADD_SEQ_CHUNK = 25;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-slice build still needs a 1-bit index register.
  function automatic int calc_idx_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit slice adder; c_msb is the carry into the slice MSB,
// consumed by the signed-overflow logic when ADD_SEQ_OVF_EN is defined.
module add_chunk
  import add_seq_pkg::*;
#(
  parameter int CHUNK = ADD_SEQ_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum    = w_full[CHUNK-1:0];
  assign cout   = w_full[CHUNK];
  // The MSB sum bit is a ^ b ^ carry-in, so the carry-in falls out by XOR.
  assign c_msb  = a[CHUNK-1] ^ b[CHUNK-1] ^ w_full[CHUNK-1];

endmodule

// File: rtl/add_seq100.sv
// Multi-cycle wide adder: one CHUNK slice per clock, LSB first, valid/ready on both sides.
// Define ADD_SEQ_OVF_EN to add the registered signed-overflow output ovf.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand bundle
// RUN   | adding slice k each cycle, carry held in r_carry
// DONE  | out_valid high, result held until out_ready
module add_seq100
  import add_seq_pkg::*;
#(
  parameter int WIDTH = ADD_SEQ_WIDTH,
  parameter int CHUNK = ADD_SEQ_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADD_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int KW     = calc_idx_w(NCHUNK);
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("add_seq100: WIDTH must be an integer multiple of CHUNK");
  end

  state_t           r_state;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CHUNK-1:0] r_sum_sl [NCHUNK];
  logic             r_cout;
  logic             r_out_valid;
  logic             r_in_ready;

  logic [CHUNK-1:0] w_s;
  logic             w_c;
`ifdef ADD_SEQ_OVF_EN
  logic             w_cmsb;
  logic             r_ovf;
`else
  logic             w_cmsb_unused;
`endif

  // Operand registers shift right each RUN cycle, so the active slice is always the low CHUNK bits.
  add_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (r_a[CHUNK-1:0]),
    .b     (r_b[CHUNK-1:0]),
    .cin   (r_carry),
    .sum   (w_s),
    .cout  (w_c),
`ifdef ADD_SEQ_OVF_EN
    .c_msb (w_cmsb)
`else
    .c_msb (w_cmsb_unused)
`endif
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      for (int j = 0; j < NCHUNK; j++) r_sum_sl[j] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_in_ready && in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_carry    <= cin;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        RUN: begin
          for (int j = 0; j < NCHUNK; j++) begin
            if (r_k == KW'(j)) r_sum_sl[j] <= w_s;
          end
          r_carry <= w_c;
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_k     <= r_k + KW'(1);
          if (r_k == K_LAST) begin
            r_cout      <= w_c;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

`ifdef ADD_SEQ_OVF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == RUN && r_k == K_LAST) begin
      r_ovf <= w_c ^ w_cmsb;
    end
  end

  assign ovf = r_ovf;
`endif

  for (genvar g = 0; g < NCHUNK; g++) begin : g_sum
    assign sum[g*CHUNK +: CHUNK] = r_sum_sl[g];
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign cout      = r_cout;

endmodule

// File: tb/tb_add_seq100.sv
// Self-checking bench for add_seq100: directed corner cases plus a randomised
// regression against an arithmetic reference; ovf is checked when ADD_SEQ_OVF_EN is defined.
module tb_add_seq100;

  localparam int W = 100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         cin = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout;
`ifdef ADD_SEQ_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_seq100 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADD_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Signed overflow: the true signed sum falls outside the W-bit two's-complement range.
  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic signed [W+1:0] s, maxp, minn;
    s = $signed({x[W-1], x[W-1], x}) + $signed({y[W-1], y[W-1], y}) + $signed({{(W+1){1'b0}}, c});
    maxp = '0;
    maxp[W-2:0] = '1;
    minn = '1;
    minn[W-2:0] = '0;
    return (s > maxp) || (s < minn);
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [127:0] t;
    int mode;
    t = {$urandom, $urandom, $urandom, $urandom};
    mode = $urandom_range(0, 7);
    if (mode == 0) return '1;
    if (mode == 1) return '0;
    if (mode == 2) return {1'b0, {(W-1){1'b1}}};
    return t[W-1:0];
  endfunction

  // Called at a negedge; returns at the negedge right after the acceptance edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, output bit tmo);
    int n;
    n = 0;
    tmo = 1'b0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      tmo = 1'b1;
    end else begin
      a = ta;
      b = tb;
      cin = tc;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a = rand_op();
      b = rand_op();
      cin = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if ({cout, sum} !== '0) begin errors++; $display("FAIL reset_result got %h exp 0", {cout, sum}); end
`ifdef ADD_SEQ_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_simple();
    bit tmo;
    out_ready = 1'b1;
    send(100'd5, 100'd7, 1'b1, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL simple_accept got timeout exp accept"); end
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      checks++; if (out_valid !== (n == 4)) begin errors++; $display("FAIL simple_latency cycle %0d got %b exp %b", n, out_valid, (n == 4)); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL simple_busy cycle %0d got %b exp 0", n, in_ready); end
    end
    checks++; if ({cout, sum} !== 101'd13) begin errors++; $display("FAIL simple_sum got %h exp %h", {cout, sum}, 101'd13); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL simple_ready_back got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL simple_valid_drop got %b exp 0", out_valid); end
  endtask

  task automatic test_carry_ripple();
    bit tmo;
    int cyc;
    logic [W:0] expv;
    expv = {1'b1, {W{1'b0}}};
    out_ready = 1'b1;
    send({W{1'b1}}, '0, 1'b1, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL ripple_accept got timeout exp accept"); end
    wait_valid(cyc);
    checks++; if (cyc != 4) begin errors++; $display("FAIL ripple_latency got %0d exp 4", cyc); end
    checks++; if ({cout, sum} !== expv) begin errors++; $display("FAIL ripple_sum got %h exp %h", {cout, sum}, expv); end
`ifdef ADD_SEQ_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ripple_ovf got %b exp 0", ovf); end
`endif
    @(negedge clk);
  endtask

`ifdef ADD_SEQ_OVF_EN
  task automatic test_ovf();
    bit tmo;
    int cyc;
    logic [W:0] expv;
    expv = {2'b01, {(W-1){1'b0}}};
    out_ready = 1'b1;
    send({1'b0, {(W-1){1'b1}}}, 100'd1, 1'b0, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL ovf_accept got timeout exp accept"); end
    wait_valid(cyc);
    checks++; if ({cout, sum} !== expv) begin errors++; $display("FAIL ovf_sum got %h exp %h", {cout, sum}, expv); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", ovf); end
    @(negedge clk);
  endtask
`endif

  task automatic test_backpressure();
    bit tmo;
    int cyc;
    logic [W-1:0] a1, b1, a2, b2;
    logic c1, c2;
    logic [W:0] exp1, exp2;
    a1 = rand_op(); b1 = rand_op(); c1 = 1'($urandom_range(0, 1));
    a2 = rand_op(); b2 = rand_op(); c2 = 1'($urandom_range(0, 1));
    exp1 = ref_add(a1, b1, c1);
    exp2 = ref_add(a2, b2, c2);
    out_ready = 1'b0;
    send(a1, b1, c1, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL bp_accept got timeout exp accept"); end
    wait_valid(cyc);
    checks++; if (cyc != 4) begin errors++; $display("FAIL bp_latency got %0d exp 4", cyc); end
    a = a2; b = b2; cin = c2; in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold cycle %0d got valid %b ready %b exp 1 0", n, out_valid, in_ready); end
      checks++; if ({cout, sum} !== exp1) begin errors++; $display("FAIL bp_stable cycle %0d got %h exp %h", n, {cout, sum}, exp1); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got valid %b ready %b exp 0 1", out_valid, in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept got %b exp 0", in_ready); end
    in_valid = 1'b0;
    a = rand_op(); b = rand_op();
    wait_valid(cyc);
    checks++; if (cyc != 4) begin errors++; $display("FAIL bp_second_latency got %0d exp 4", cyc); end
    checks++; if ({cout, sum} !== exp2) begin errors++; $display("FAIL bp_second_sum got %h exp %h", {cout, sum}, exp2); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit tmo;
    int cyc;
    bit seen;
    out_ready = 1'b1;
    send(rand_op(), rand_op(), 1'b1, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL midrst_accept got timeout exp accept"); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL midrst_flags got valid %b ready %b exp 0 0", out_valid, in_ready); end
    checks++; if ({cout, sum} !== '0) begin errors++; $display("FAIL midrst_clear got %h exp 0", {cout, sum}); end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midrst_no_result got valid 1 exp 0"); end
    send(100'd3, 100'd4, 1'b0, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL midrst_reaccept got timeout exp accept"); end
    wait_valid(cyc);
    checks++; if ({cout, sum} !== 101'd7) begin errors++; $display("FAIL midrst_sum got %h exp %h", {cout, sum}, 101'd7); end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit tmo;
    int cyc;
    int stall;
    logic [W-1:0] ra, rb;
    logic rc;
    logic [W:0] expv;
    for (int i = 0; i < 1000; i++) begin
      ra = rand_op(); rb = rand_op(); rc = 1'($urandom_range(0, 1));
      expv = ref_add(ra, rb, rc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      out_ready = ($urandom_range(0, 3) == 0);
      send(ra, rb, rc, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL rand_accept op %0d got timeout exp accept", i); end
      wait_valid(cyc);
      checks++; if (cyc != 4) begin errors++; $display("FAIL rand_latency op %0d got %0d exp 4", i, cyc); end
      checks++; if ({cout, sum} !== expv) begin errors++; $display("FAIL rand_sum op %0d got %h exp %h", i, {cout, sum}, expv); end
`ifdef ADD_SEQ_OVF_EN
      checks++; if (ovf !== ref_ovf(ra, rb, rc)) begin errors++; $display("FAIL rand_ovf op %0d got %b exp %b", i, ovf, ref_ovf(ra, rb, rc)); end
`endif
      stall = out_ready ? 0 : $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || {cout, sum} !== expv) begin errors++; $display("FAIL rand_stall op %0d got valid %b %h exp 1 %h", i, out_valid, {cout, sum}, expv); end
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_handshake op %0d got %b exp 0", i, out_valid); end
      out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_simple();
    test_carry_ripple();
`ifdef ADD_SEQ_OVF_EN
    test_ovf();
`endif
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
